// File: rtl/shift_seq_ctrl.sv
// Round-robin shared shift/rotate sequencer: IDLE grants a requester, BUSY shifts, DONE pulses ack.
// Optional SHIFT_FAST_EN: BUSY applies the full barrel shift in one edge instead of 1 bit/edge.
module shift_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [1:0]        op0_i,
  input  logic [CNT_W-1:0]  cnt0_i,
  input  logic [DATA_W-1:0] rs0_i,
  input  logic              req1_i,
  input  logic [1:0]        op1_i,
  input  logic [CNT_W-1:0]  cnt1_i,
  input  logic [DATA_W-1:0] rs1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] res_o,
  output logic              cout_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]  w_q, w_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               cout_q, cout_d;
  logic               id_q, id_d;
  logic               rr_last_q, rr_last_d;

  logic               grant1;
  logic [CNT_W-1:0]   cnt_sel;
  logic [DATA_W-1:0]  rs_sel;
  logic [DATA_W-1:0]  sw;
  logic               sc;

  // Returns {carry, word} after one single-bit step.
  function automatic logic [DATA_W:0] step_f(input logic [1:0] op, input logic [DATA_W-1:0] w);
    case (op)
      2'b00:   step_f = {w[DATA_W-1], w[DATA_W-2:0], 1'b0};
      2'b01:   step_f = {w[0], 1'b0, w[DATA_W-1:1]};
      2'b10:   step_f = {w[DATA_W-1], w[DATA_W-2:0], w[DATA_W-1]};
      default: step_f = {w[0], w[0], w[DATA_W-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    w_d       = w_q;
    res_d     = res_q;
    cout_d    = cout_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    sw        = w_q;
    sc        = 1'b0;
    grant1    = req1_i & (~req0_i | ~rr_last_q);
    cnt_sel   = grant1 ? cnt1_i : cnt0_i;
    rs_sel    = grant1 ? rs1_i : rs0_i;

    case (state_q)
      ST_IDLE: begin
        if (req0_i | req1_i) begin
          id_d      = grant1;
          rr_last_d = grant1;
          op_d      = grant1 ? op1_i : op0_i;
          w_d       = rs_sel;
          rem_d     = cnt_sel;
          if (cnt_sel == '0) begin
            res_d   = rs_sel;
            cout_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
`ifdef SHIFT_FAST_EN
        // Unrolled chain of single steps; rem_q holds the full count here.
        for (int i = 0; i < DATA_W - 1; i++) begin
          if (CNT_W'(i) < rem_q) {sc, sw} = step_f(op_q, sw);
        end
        rem_d   = '0;
        res_d   = sw;
        cout_d  = sc;
        state_d = ST_DONE;
`else
        {sc, sw} = step_f(op_q, w_q);
        w_d      = sw;
        rem_d    = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          res_d   = sw;
          cout_d  = sc;
          state_d = ST_DONE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      w_q       <= '0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      id_q      <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      w_q       <= w_d;
      res_q     <= res_d;
      cout_q    <= cout_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign ack0_o = (state_q == ST_DONE) & ~id_q;
  assign ack1_o = (state_q == ST_DONE) &  id_q;
  assign res_o  = res_q;
  assign cout_o = cout_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed plus randomized bench for shift_seq_ctrl against a transaction-level reference model.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [2:0] cnt0, cnt1;
  logic [7:0] rs0, rs1;
  logic       ack0_o, ack1_o, cout_o, busy_o;
  logic [7:0] res_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit rr;
  logic [7:0] saved;

  shift_seq_ctrl dut (
    .clk_i (clk),  .rst_i (rst),
    .req0_i(req0), .op0_i(op0), .cnt0_i(cnt0), .rs0_i(rs0),
    .req1_i(req1), .op1_i(op1), .cnt1_i(cnt1), .rs1_i(rs1),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .res_o(res_o), .cout_o(cout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, res} from the arithmetic definition of shifts and rotates.
  function automatic logic [8:0] ref_f(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] rs);
    int n;
    logic [7:0] r;
    logic c;
    n = int'(cnt);
    if (n == 0) return {1'b0, rs};
    case (op)
      2'd0: begin r = rs << n; c = rs[8-n]; end
      2'd1: begin r = rs >> n; c = rs[n-1]; end
      2'd2: begin r = (rs << n) | (rs >> (8-n)); c = r[0]; end
      default: begin r = (rs >> n) | (rs << (8-n)); c = r[7]; end
    endcase
    return {c, r};
  endfunction

  function automatic int lat(input logic [2:0] cnt);
`ifdef SHIFT_FAST_EN
    return (cnt == 0) ? 0 : 1;
`else
    return int'(cnt);
`endif
  endfunction

  task automatic set0(input logic [1:0] o, input logic [2:0] c, input logic [7:0] r);
    op0 = o; cnt0 = c; rs0 = r; req0 = 1'b1;
  endtask

  task automatic set1(input logic [1:0] o, input logic [2:0] c, input logic [7:0] r);
    op1 = o; cnt1 = c; rs1 = r; req1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr = 1'b1;
  endtask

  // Entered #1 after an edge with the DUT idle and at least one request raised;
  // returns #1 after the edge that brings the DUT back to idle.
  task automatic txn();
    int win, c, l;
    logic [8:0] e;
    win = (req0 && req1) ? (rr ? 0 : 1) : (req1 ? 1 : 0);
    rr  = (win == 1);
    e   = (win == 1) ? ref_f(op1, cnt1, rs1) : ref_f(op0, cnt0, rs0);
    l   = lat((win == 1) ? cnt1 : cnt0);
    @(posedge clk); #1;
    c = 0;
    while (!(ack0_o || ack1_o) && c < 40) begin
      chk("busy_in_busy", busy_o, 1);
      @(posedge clk); #1;
      c++;
    end
    chk("ack_seen", ack0_o | ack1_o, 1);
    chk("latency", c, l);
    chk("ack_id", {ack1_o, ack0_o}, (win == 1) ? 2 : 1);
    chk("res", res_o, e[7:0]);
    chk("cout", cout_o, e[8]);
    chk("busy_in_done", busy_o, 1);
    @(posedge clk); #1;
    chk("ack_pulse_end", {ack1_o, ack0_o}, 0);
    chk("idle_busy", busy_o, 0);
    chk("res_hold", res_o, e[7:0]);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; cnt0 = '0; cnt1 = '0; rs0 = '0; rs1 = '0;
    rr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {ack1_o, ack0_o}, 0);
    chk("rst_res", res_o, 0);
    chk("rst_cout", cout_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;

    set0(2'd0, 3'd3, 8'hB1); txn(); req0 = 1'b0;
    chk("t1_res", res_o, 8'h88); chk("t1_cout", cout_o, 1);
    set1(2'd1, 3'd0, 8'h5A); txn(); req1 = 1'b0;
    chk("t2_res", res_o, 8'h5A); chk("t2_cout", cout_o, 0);
    set1(2'd3, 3'd4, 8'h3C); txn(); req1 = 1'b0;
    chk("t3_ror_res", res_o, 8'hC3); chk("t3_ror_cout", cout_o, 1);
    set0(2'd2, 3'd1, 8'h80); txn(); req0 = 1'b0;
    chk("t3_rol_res", res_o, 8'h01); chk("t3_rol_cout", cout_o, 1);

    // Simultaneous requests right after reset, then held to alternate.
    do_reset();
    set0(2'd0, 3'd2, 8'h0F); set1(2'd1, 3'd5, 8'hF0);
    txn(); chk("arb_first_r0", res_o, 8'h3C);
    txn(); chk("arb_then_r1", res_o, 8'h07);
    txn(); txn();
    req0 = 1'b0; req1 = 1'b0;

    // Reset while busy discards the operation.
    set0(2'd0, 3'd7, 8'hFF);
    @(posedge clk); #1;
    chk("mid_busy", busy_o, 1);
    chk("mid_noack", {ack1_o, ack0_o}, 0);
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rr = 1'b1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_res", res_o, 0);
    chk("mid_rst_cout", cout_o, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_noack", {ack1_o, ack0_o}, 0);
    end
    set0(2'd3, 3'd5, 8'hA5); txn(); req0 = 1'b0;

    // Request held through its ack re-issues the same operation.
    set1(2'd2, 3'd6, 8'h96); txn();
    saved = res_o;
    txn();
    chk("reissue_same", res_o, saved);
    req1 = 1'b0;

    for (int k = 0; k < 60; k++) begin
      if (!req0 && $urandom_range(0, 1) == 1)
        set0(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
      if (!req1 && $urandom_range(0, 1) == 1)
        set1(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
      if (!req0 && !req1)
        set0(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
      txn();
      if ($urandom_range(0, 3) != 0) begin
        if (rr) req1 = 1'b0;
        else    req0 = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
